// File: rtl/companion_stat_scheduler.sv
`default_nettype none
// companion_stat_scheduler: periodic decay-tick sequencer plus round-robin refresh arbiter
// that keeps every stat's tick/refresh pulses separated by at least one idle cycle.
module companion_stat_scheduler #(
   parameter int NUM_STATS   = 3,
   parameter int TICK_PERIOD = 50_000_000,
   parameter int COOLDOWN    = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NUM_STATS-1:0] req,
   output logic [NUM_STATS-1:0] tick,
   output logic [NUM_STATS-1:0] refresh,
   output logic [NUM_STATS-1:0] pending,
   output logic [NUM_STATS-1:0] cooling,
   output logic                 dropped
);

   localparam int                   IDX_W    = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
   localparam logic [0:0]           ST_IDLE  = 1'b0;
   localparam logic [0:0]           ST_SWEEP = 1'b1;
   localparam logic [31:0]          CNT_LAST = 32'(TICK_PERIOD - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_STATS - 1);
   localparam logic [15:0]          CD_LOAD  = 16'(COOLDOWN);
   localparam logic [NUM_STATS-1:0] ONE      = NUM_STATS'(1);

   logic [31:0]          cnt_q, cnt_d;
   logic [0:0]           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [NUM_STATS-1:0] req_q;
   logic [NUM_STATS-1:0] tick_q, tick_d, tick_next;
   logic [NUM_STATS-1:0] refresh_q, refresh_d;
   logic [NUM_STATS-1:0] pending_q, pending_d;
   logic                 dropped_q, dropped_d;
   logic [15:0]          cd_q [NUM_STATS];

   logic                 wrap;
   logic [NUM_STATS-1:0] eligible, cand, grant, req_edge, accept;
   logic                 grant_found;
   logic [IDX_W-1:0]     grant_idx;

   assign wrap    = en && (cnt_q == CNT_LAST);
   assign idx_inc = idx_q + IDX_W'(1);

   // tick_next announces the tick that will be registered one edge later,
   // so the arbiter can keep a refresh from landing right before it.
   always_comb begin
      cnt_d     = cnt_q;
      state_d   = state_q;
      idx_d     = idx_q;
      tick_d    = '0;
      tick_next = '0;
      if (en) cnt_d = wrap ? 32'd0 : cnt_q + 32'd1;
      case (state_q)
         ST_IDLE: begin
            if (wrap) begin
               state_d   = ST_SWEEP;
               idx_d     = '0;
               tick_next = ONE;
            end
         end
         ST_SWEEP: begin
            tick_d = ONE << idx_q;
            if (idx_q == IDX_LAST) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d     = idx_inc;
               tick_next = ONE << idx_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign eligible = ~(tick_d | tick_next | tick_q | refresh_q);
   assign cand     = pending_q & eligible;

   always_comb begin
      int               j;
      logic [IDX_W-1:0] jdx;
      j           = 0;
      jdx         = '0;
      grant_found = 1'b0;
      grant_idx   = last_q;
      grant       = '0;
      for (int k = 1; k <= NUM_STATS; k++) begin
         j = int'(last_q) + k;
         if (j >= NUM_STATS) j = j - NUM_STATS;
         jdx = IDX_W'(j);
         if (!grant_found && cand[jdx]) begin
            grant_found = 1'b1;
            grant_idx   = jdx;
         end
      end
      if (grant_found) grant = ONE << grant_idx;
   end

   assign req_edge  = req & ~req_q;
   assign accept    = req_edge & ~pending_q & ~cooling;
   assign pending_d = (pending_q & ~grant) | accept;
   assign dropped_d = |(req_edge & ~accept);
   assign refresh_d = grant;
   assign last_d    = grant_found ? grant_idx : last_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         last_q    <= IDX_LAST;
         req_q     <= '0;
         tick_q    <= '0;
         refresh_q <= '0;
         pending_q <= '0;
         dropped_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         req_q     <= req;
         tick_q    <= tick_d;
         refresh_q <= refresh_d;
         pending_q <= pending_d;
         dropped_q <= dropped_d;
      end
   end

   for (genvar i = 0; i < NUM_STATS; i++) begin : g_cooldown
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)             cd_q[i] <= '0;
         else if (grant[i])    cd_q[i] <= CD_LOAD;
         else if (cd_q[i] != 16'd0) cd_q[i] <= cd_q[i] - 16'd1;
      end
      assign cooling[i] = |cd_q[i];
   end

   assign tick    = tick_q;
   assign refresh = refresh_q;
   assign pending = pending_q;
   assign dropped = dropped_q;

endmodule
`default_nettype wire

// File: doc/companion_stat_scheduler.md
# companion_stat_scheduler

Sequencer and arbiter for a bank of companion stat registers. It generates the periodic decay `tick` pulses for every stat and arbitrates user refresh requests (feed, play, rest, ...) into single-cycle `refresh` pulses. Its central guarantee is that no stat ever sees two pulses in adjacent cycles. Each stat register clocks on `tick | refresh`, so adjacent or overlapping pulses would merge into one edge. It sits between the debounced button/event logic and the per-stat register instances.

## Interface
Parameters:
- `NUM_STATS`, 3: number of stat registers served (2..8).
- `TICK_PERIOD`, 50_000_000: clock cycles between decay sweeps. Must be ≥ `NUM_STATS` + 2.
- `COOLDOWN`, 1000: cycles after a granted refresh during which new requests for that stat are dropped (1..65535).

Ports:
- `clk`  in  1: system clock; everything is clocked on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `en`  in  1: prescaler enable. Low freezes the prescaler; a sweep already in progress still completes.
- `req`  in  NUM_STATS: refresh request levels, synchronous and already debounced. Only rising edges are acted on.
- `tick`  out  NUM_STATS: decay pulses, registered; one-hot or zero.
- `refresh`  out  NUM_STATS: refresh pulses, registered; one-hot or zero.
- `pending`  out  NUM_STATS: accepted request awaiting grant.
- `cooling`  out  NUM_STATS: stat's cooldown counter is nonzero.
- `dropped`  out  1: one-cycle pulse when any request edge is rejected.

## Operation
- Reset (`rst` low): all outputs 0. Internal state clears to: prescaler = 0, sweep state IDLE, sweep index = 0, `req_q` = 0, cooldown counters = 0, last-grant pointer = `NUM_STATS`-1 (so stat 0 has first priority).
- Prescaler: a 32-bit counter that increments while `en` is high. At `TICK_PERIOD`-1 with `en` high, it wraps to 0 and starts a sweep.
- Sweep FSM:
  - IDLE → SWEEP on wrap, with s = 0.
  - In SWEEP, the tick register for stat s is set, so `tick[s]` is high in the next cycle.
  - s then increments. After s = `NUM_STATS`-1 the FSM returns to IDLE.
  - Ticks are never deferred or skipped.
- Edge capture: edge[i] = `req[i]` & ~`req_q[i]`.
  - If `pending[i]` = 0 and `cooling[i]` = 0: set `pending[i]`.
  - Otherwise: the edge is discarded and `dropped` pulses.
- Eligibility: stat i is excluded from arbitration in a cycle if any of these holds:
  - `tick[i]` is being registered this cycle.
  - `tick[i]` will be registered next cycle (the sweep schedule is deterministic).
  - `tick[i]` or `refresh[i]` is high this cycle.
- Arbiter: among pending and eligible stats, pick the first at or after last-grant+1, modulo `NUM_STATS`. At most one grant per cycle. On a grant:
  - the `refresh` register for that stat is set;
  - its `pending` bit clears;
  - its cooldown counter loads `COOLDOWN`;
  - last-grant is updated.
- Cooldown counters are 16-bit and decrement to 0, saturating there. `cooling[i]` = counter ≠ 0.
- Invariant: `tick` & `refresh` = 0 in every cycle, and every pulse on a given stat is preceded and followed by a low cycle on both outputs for that stat.

## Timing
- Uncontested request: if `req[i]` is first sampled high at edge k, `pending[i]` is high after edge k and `refresh[i]` is high for the single cycle following edge k+1.
- Tick schedule: the prescaler wrap is registered at edge w. `tick[0]` is high after edge w+1, `tick[1]` after w+2, and so on, each for one cycle.
- Cooldown: loaded at the grant edge. A new edge for that stat is accepted only once the counter has reached 0, i.e. no earlier than `COOLDOWN`+1 cycles after the grant edge.
- Simultaneous events:
  - An edge arriving for a stat that is already pending is dropped.
  - A pending stat blocked by a tick waits. It is granted in the first cycle it is eligible, subject to round-robin order.
- Reset asserted mid-sweep or mid-cooldown: all state clears immediately. Outputs go to 0 asynchronously.
- `en` low during a wrap cycle: no wrap occurs. The counter holds at `TICK_PERIOD`-1 until `en` rises.

## Test plan
- Reset with `NUM_STATS`=3, `TICK_PERIOD`=8, `en`=1 → counter 0..7; then `tick` = 001, 010, 100 on three consecutive cycles and 000 otherwise; this repeats every 8 cycles.
- `req` = 111 rising at edge k, no sweep active → `refresh` = 001, 010, 100 on cycles k+2, k+3, k+4. `pending` goes 111 → 110 → 100 → 000.
- `req[1]` rising so that its grant cycle collides with `tick[1]` → `refresh[1]` is delayed until at least one low cycle separates it from `tick[1]`. `tick` & `refresh` = 0 throughout.
- `COOLDOWN`=5: toggle `req[0]` every 2 cycles → one `refresh[0]`, then `dropped` pulses for each edge while `cooling[0]` = 1. The first edge after the counter reaches 0 produces the next refresh.
- `en` low for 20 cycles at count 3 → no ticks. Counting resumes from 3 when `en` rises.
- `rst` pulsed low mid-sweep, with `pending` = 101 and `cooling` = 010 → all outputs 0 immediately. After release, the first tick appears after a full `TICK_PERIOD`.
